// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider: state encodings, handshake levels and
// the register-bus width shared with the rest of the pipeline.
package div_ctrl_pkg;

  // Width of the general-purpose register bus.
  localparam int unsigned RegBusW = 32;
  typedef logic [RegBusW-1:0] reg_bus_t;

  // Divider controller states, binary encoded.
  typedef enum logic [1:0] {
    DivIdle = 2'b00,
    DivBusy = 2'b01,
    DivDone = 2'b10
  } div_state_e;

  // Request / result handshake levels.
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // HI/LO write strobe levels.
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift {rem, dvd} left by one, trial-subtract
// the divisor and shift the resulting quotient bit into the bottom of dvd.
module div_step
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = RegBusW
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] dvd,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] dvd_next
);

  // Shifted remainder can exceed DATA_W bits, so compare on DATA_W+1 bits.
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // Trial subtraction; a borrow in the top bit means restore.
  always_comb begin
    shifted = {rem, dvd[DATA_W-1]};
    diff    = shifted - {1'b0, divisor};
    if (diff[DATA_W]) begin
      rem_next = shifted[DATA_W-1:0];
      dvd_next = {dvd[DATA_W-2:0], 1'b0};
    end else begin
      rem_next = diff[DATA_W-1:0];
      dvd_next = {dvd[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider controller for DIV/DIVU. Stalls the pipeline while busy
// and hands quotient (LO) and remainder (HI) over with a one-cycle HI/LO write strobe.
// Optional build macro DIV_EARLY_OUT_EN: finish in one cycle when |op1| < |op2|.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = RegBusW,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_op1,
  input  logic [DATA_W-1:0] div_op2,
  input  logic              div_annul,
  output logic              div_stall_req,
  output logic              div_ready,
  output logic              hilo_we,
  output logic [DATA_W-1:0] hi_data_o,
  output logic [DATA_W-1:0] lo_data_o,
  output logic              div_by_zero
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dvd_q, dvd_d;
  logic [DATA_W-1:0] dsr_q, dsr_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              dbz_q, dbz_d;

  logic              op1_neg, op2_neg;
  logic [DATA_W-1:0] op1_abs, op2_abs;
  logic [DATA_W-1:0] step_rem, step_dvd;

  // Operand magnitudes; only signed divides take the absolute value.
  always_comb begin
    op1_neg = div_signed & div_op1[DATA_W-1];
    op2_neg = div_signed & div_op2[DATA_W-1];
    op1_abs = op1_neg ? -div_op1 : div_op1;
    op2_abs = op2_neg ? -div_op2 : div_op2;
  end

  div_step #(
    .DATA_W (DATA_W)
  ) u_div_step (
    .rem      (rem_q),
    .dvd      (dvd_q),
    .divisor  (dsr_q),
    .rem_next (step_rem),
    .dvd_next (step_dvd)
  );

  // Next-state and datapath sequencing; annul always wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      DivIdle: begin
        if (div_annul) begin
          state_d = DivIdle;
        end else if (div_start == DivStart) begin
          dvd_d   = op1_abs;
          dsr_d   = op2_abs;
          rem_d   = '0;
          cnt_d   = '0;
          q_neg_d = op1_neg ^ op2_neg;
          r_neg_d = op1_neg;
          if (div_op2 == '0) begin
            state_d = DivDone;
            lo_d    = '1;
            hi_d    = div_op1;
            dbz_d   = 1'b1;
`ifdef DIV_EARLY_OUT_EN
          end else if (op1_abs < op2_abs) begin
            // Quotient is zero and the dividend is already the signed remainder.
            state_d = DivDone;
            lo_d    = '0;
            hi_d    = div_op1;
            dbz_d   = 1'b0;
`endif
          end else begin
            state_d = DivBusy;
          end
        end
      end
      DivBusy: begin
        if (div_annul) begin
          state_d = DivIdle;
        end else begin
          rem_d = step_rem;
          dvd_d = step_dvd;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LastCnt) begin
            state_d = DivDone;
            lo_d    = q_neg_q ? -step_dvd : step_dvd;
            hi_d    = r_neg_q ? -step_rem : step_rem;
            dbz_d   = 1'b0;
          end
        end
      end
      DivDone: begin
        state_d = DivIdle;
      end
      default: begin
        state_d = DivIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= DivIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  // Handshake outputs; a flush in DONE suppresses the HI/LO write.
  always_comb begin
    div_stall_req = (state_q == DivBusy) ||
                    ((state_q == DivIdle) && (div_start == DivStart) && !div_annul);
    div_ready     = ((state_q == DivDone) && !div_annul) ? DivResultReady : DivResultNotReady;
    hilo_we       = ((state_q == DivDone) && !div_annul) ? WriteEnable : WriteDisable;
    div_by_zero   = div_ready & dbz_q;
  end

  assign hi_data_o = hi_q;
  assign lo_data_o = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: the driver pushes arithmetic-model results, the monitor
// pops and compares whenever div_ready is presented.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_annul;
  logic        div_stall_req;
  logic        div_ready;
  logic        hilo_we;
  logic [31:0] hi_data_o;
  logic [31:0] lo_data_o;
  logic        div_by_zero;

  div_ctrl #(
    .DATA_W (32),
    .CNT_W  (6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .div_start     (div_start),
    .div_signed    (div_signed),
    .div_op1       (div_op1),
    .div_op2       (div_op2),
    .div_annul     (div_annul),
    .div_stall_req (div_stall_req),
    .div_ready     (div_ready),
    .hilo_we       (hilo_we),
    .hi_data_o     (hi_data_o),
    .lo_data_o     (lo_data_o),
    .div_by_zero   (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          lat;
    int          start;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;
  logic        prev_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: plain 64-bit arithmetic division, truncating toward zero.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 input int start);
    exp_t   e;
    longint sa, sd, q, r;
    e.start = start;
    e.dbz   = 1'b0;
    e.lat   = 33;
    if (b == 32'd0) begin
      e.lo  = 32'hFFFF_FFFF;
      e.hi  = a;
      e.dbz = 1'b1;
      e.lat = 1;
      return e;
    end
    if (sgn) begin
      sa = longint'($signed(a));
      sd = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sd = longint'({32'd0, b});
    end
    q    = sa / sd;
    r    = sa % sd;
    e.lo = q[31:0];
    e.hi = r[31:0];
`ifdef DIV_EARLY_OUT_EN
    if ((sa < 0 ? -sa : sa) < (sd < 0 ? -sd : sd)) e.lat = 1;
`endif
    return e;
  endfunction

  // Monitor: compare every presented result against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (div_ready) begin
        check("hilo_we_with_ready", hilo_we, 1);
        if (prev_ready) check("ready_pulse_width", 1, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_ready", div_ready, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("lo", lo_data_o, e.lo);
          check("hi", hi_data_o, e.hi);
          check("div_by_zero", div_by_zero, e.dbz);
          check("latency", cyc - e.start, e.lat);
          last_lo = e.lo;
          last_hi = e.hi;
        end
      end else begin
        check("hilo_we_idle", hilo_we, 0);
        check("dbz_idle", div_by_zero, 0);
      end
      prev_ready = div_ready;
    end
  end

  // Issue one divide, hold start until ready, scramble operands while busy.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    bit got;
    got = 0;
    @(negedge clk);
    div_op1    = a;
    div_op2    = b;
    div_signed = sgn;
    div_start  = 1'b1;
    exp_q.push_back(model(a, b, sgn, cyc));
    for (int i = 0; i < 100; i++) begin
      #1;
      if (div_ready) begin
        got = 1;
        break;
      end
      check("stall_while_busy", div_stall_req, 1);
      if (i > 0) begin
        div_op1    = $urandom;
        div_op2    = $urandom;
        div_signed = 1'($urandom);
      end
      @(negedge clk);
    end
    check("ready_seen", got, 1);
    if (got) check("stall_in_done", div_stall_req, 0);
    div_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_op1    = '0;
    div_op2    = '0;
    div_annul  = 1'b0;
    #2;
    check("rst_lo", lo_data_o, 0);
    check("rst_hi", hi_data_o, 0);
    check("rst_ready", div_ready, 0);
    check("rst_hilo_we", hilo_we, 0);
    check("rst_stall", div_stall_req, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'h0000_1234, 32'd0, 1'b0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Annul mid-divide: back to IDLE, no write, results held.
    @(negedge clk);
    div_op1 = 32'd100; div_op2 = 32'd7; div_signed = 1'b0; div_start = 1'b1;
    repeat (10) @(negedge clk);
    div_annul = 1'b1;
    div_start = 1'b0;
    @(negedge clk);
    div_annul = 1'b0;
    #1;
    check("annul_back_to_idle", div_stall_req, 0);
    check("annul_lo_held", lo_data_o, last_lo);
    check("annul_hi_held", hi_data_o, last_hi);
    repeat (40) @(negedge clk);
    run_op(32'd9, 32'd3, 1'b0);

    // Annul beats start in IDLE.
    @(negedge clk);
    div_op1 = 32'd9; div_op2 = 32'd3; div_start = 1'b1; div_annul = 1'b1;
    #1;
    check("annul_prio_stall", div_stall_req, 0);
    @(negedge clk);
    #1;
    check("annul_prio_still_idle", div_stall_req, 0);
    @(negedge clk);
    div_start = 1'b0; div_annul = 1'b0;

    // Annul in the DONE cycle gates the write strobe.
    @(negedge clk);
    div_op1 = 32'h55; div_op2 = 32'd0; div_start = 1'b1;
    @(negedge clk);
    div_annul = 1'b1; div_start = 1'b0;
    #1;
    check("done_annul_ready", div_ready, 0);
    check("done_annul_we", hilo_we, 0);
    @(negedge clk);
    div_annul = 1'b0;
    #1;
    check("done_annul_idle", div_stall_req, 0);
    repeat (3) @(negedge clk);
    run_op(32'd1000, 32'd10, 1'b0);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    div_op1 = 32'd100; div_op2 = 32'd7; div_signed = 1'b0; div_start = 1'b1;
    repeat (20) @(negedge clk);
    #2;
    rst       = 1'b0;
    div_start = 1'b0;
    #1;
    check("arst_lo", lo_data_o, 0);
    check("arst_hi", hi_data_o, 0);
    check("arst_ready", div_ready, 0);
    check("arst_stall", div_stall_req, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_op(32'd3, 32'd5, 1'b0);
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1);

    // Randomized operations with boundary-heavy operand choices.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      logic        s;
      s = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       a = $urandom_range(0, 20);
        1:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'd1;
        default: b = $urandom;
      endcase
      run_op(a, b, s);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle iterative divider controller that sits beside EX.
- Sequences a radix-2 restoring division for DIV/DIVU and stalls the pipeline while it runs.
- Delivers the quotient to LO and the remainder to HI through a single-cycle HI/LO write strobe.
- Shares the HI/LO register write path with MTHI/MTLO. This block owns the write only while it is in DONE.

Parameters:
- DATA_W, 32, operand/result width (matches RegBus).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- div_start  input  1  request from EX; held high until div_ready is seen.
- div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with div_start in IDLE.
- div_op1  input  DATA_W  dividend; sampled in IDLE.
- div_op2  input  DATA_W  divisor; sampled in IDLE.
- div_annul  input  1  flush; abandons the operation in progress.
- div_stall_req  output  1  pipeline stall request to the controller.
- div_ready  output  1  result valid; one-cycle pulse.
- hilo_we  output  1  HI/LO write enable; one-cycle pulse.
- hi_data_o  output  DATA_W  remainder.
- lo_data_o  output  DATA_W  quotient.
- div_by_zero  output  1  flags a zero-divisor result; valid with div_ready.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; counter = 0.
  - Internal dividend, divisor and partial-remainder registers = 0.
  - All outputs = 0.
- States: IDLE, BUSY, DONE; binary encoded.
- IDLE, with div_start=1 and div_annul=0:
  - Latch the absolute values of the operands (absolute only if div_signed).
  - Latch the quotient sign = op1[31]^op2[31] and the remainder sign = op1[31].
  - If op2 == 0: go to DONE with lo = 32'hFFFF_FFFF, hi = op1, div_by_zero = 1.
  - Otherwise: go to BUSY with counter = 0.
- BUSY, one iteration per cycle:
  - {rem, dvd} shifted left by 1.
  - If rem >= divisor: rem -= divisor and the quotient bit = 1.
  - Counter increments each cycle. When counter == DATA_W-1, go to DONE.
- DONE:
  - div_ready = 1 and hilo_we = 1 for exactly one cycle.
  - Signed results are sign-corrected by two's-complement negation: the quotient when its sign bit is set, the remainder when the dividend was negative.
  - Next state is always IDLE.
  - div_start seen in DONE is ignored. The requester drops div_start in the cycle after div_ready.
- hi_data_o / lo_data_o:
  - Registered and updated only when entering DONE.
  - Hold their value after DONE until the next DONE.
- div_stall_req is combinational:
  - high when state == BUSY;
  - high in IDLE when div_start & ~div_annul;
  - low in DONE.
- Latency for a normal divide: div_start seen in IDLE at cycle 0, BUSY in cycles 1..32, div_ready in cycle 33. A zero divisor gives div_ready in cycle 1.
- Annul:
  - div_annul=1 in IDLE or BUSY: next state is IDLE, with no hilo_we and no div_ready.
  - div_annul=1 in the DONE cycle: hilo_we and div_ready are gated low combinationally, and the state still returns to IDLE.
  - Annul has priority over start when both are asserted.
- Overflow case (signed 0x8000_0000 / 0xFFFF_FFFF): quotient = 0x8000_0000, remainder = 0. No exception is raised.
- Operands are not re-sampled during BUSY. Changes on div_op1/div_op2 in that window are ignored.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |op1| < |op2| and op2 != 0, go directly to DONE with quotient = 0 and remainder = op1 (unmodified). Latency is 1 cycle, as for divide-by-zero.
- Undefined: every non-zero-divisor operation takes the full 33-cycle path. Results are identical in both builds; only latency differs.

Decomposition:
- Shared defines file holds:
  - DivIdle / DivBusy / DivDone state encodings;
  - DivStart / DivStop, DivResultReady / DivResultNotReady;
  - RegBus and the existing WriteEnable/WriteDisable.
- One sub-module, div_step: a combinational single restoring iteration.
  - Inputs: rem, dvd, divisor.
  - Outputs: next rem, next dvd with the new quotient bit.
  - Instantiated once in BUSY.

Test Plan:
- Unsigned 100 / 7: DIVU, op1=100, op2=7 → ready at cycle 33, lo=14, hi=2, hilo_we pulse of 1 cycle, stall high in cycles 0..32.
- Signed -7 / 2: op1=0xFFFF_FFF9, op2=2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
- Divide by zero: op1=0x1234, op2=0 → ready at cycle 1, div_by_zero=1, lo=0xFFFF_FFFF, hi=0x1234.
- Signed overflow: op1=0x8000_0000, op2=0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- Annul mid-divide: start 100/7, div_annul=1 at cycle 10 → IDLE at cycle 11, no hilo_we, outputs keep their previous values. A new start for 9/3 then gives lo=3, hi=0.
- Reset mid-operation: rst low at cycle 20 → all outputs 0 immediately (asynchronous), state IDLE. With DIV_EARLY_OUT_EN, 3/5 → ready at cycle 1, lo=0, hi=3.
